// File: rtl/ddsm_cfg_sequencer.sv
// rtl/ddsm_cfg_sequencer.sv - MASH delta-sigma modulator reconfiguration sequencer
// Accepts a validated config, then runs reset, settle, optional phase adjust and done.
module ddsm_cfg_sequencer #(
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cfg_valid,
  output logic        o_cfg_ready,
  input  logic [11:0] i_seed,
  input  logic [1:0]  i_sel_order,
  input  logic [3:0]  i_mash_bit,
  input  logic        i_sel_frac,
  input  logic        i_phase_req,
  output logic [11:0] o_seed,
  output logic [1:0]  o_sel_order,
  output logic [3:0]  o_mash_bit,
  output logic        o_sel_frac,
  output logic        o_mashreseten,
  output logic        o_phaseadjusten,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_SETTLE,
    S_PHASE,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       MASH_MAX    = 4'd8;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             phase_req;
  logic [3:0]       mash_clamped;

  assign mash_clamped = (i_mash_bit > MASH_MAX) ? MASH_MAX : i_mash_bit;
  assign o_cfg_ready  = (state == S_IDLE);
  assign o_busy       = ~o_cfg_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      phase_req       <= 1'b0;
      o_seed          <= '0;
      o_sel_order     <= '0;
      o_mash_bit      <= '0;
      o_sel_frac      <= 1'b0;
      o_mashreseten   <= 1'b0;
      o_phaseadjusten <= 1'b0;
      o_done          <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      // Pulse outputs default low; each state raises its own for one cycle.
      o_err           <= 1'b0;
      o_done          <= 1'b0;
      o_phaseadjusten <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_cfg_valid) begin
            if (i_sel_order == 2'd3) begin
              o_err <= 1'b1;
            end else begin
              o_seed        <= i_seed;
              o_sel_order   <= i_sel_order;
              o_mash_bit    <= mash_clamped;
              o_sel_frac    <= i_sel_frac;
              phase_req     <= i_phase_req;
              cnt           <= '0;
              o_mashreseten <= 1'b1;
              state         <= S_RESET;
            end
          end
        end
        S_RESET: begin
          if (cnt == RST_LAST) begin
            o_mashreseten <= 1'b0;
            cnt           <= '0;
            state         <= S_SETTLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt <= '0;
            if (phase_req) begin
              o_phaseadjusten <= 1'b1;
              state           <= S_PHASE;
            end else begin
              o_done <= 1'b1;
              state  <= S_DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PHASE: begin
          o_done <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
